// File: rtl/rv32i_fetch.sv
// rv32i instruction fetch: PC generation, credit-limited imem requests, in-order
// response buffering and a valid/ready hand-off to decode, with jump flush.
module rv32i_fetch #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            areset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_target,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = CW + 1;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   occ_q, occ_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [XLEN-1:0] instr_q [DEPTH];
  logic [XLEN-1:0] instr_d [DEPTH];
  logic [XLEN-1:0] ipc_q [DEPTH];
  logic [XLEN-1:0] ipc_d [DEPTH];

  logic            pop_s;
  logic            gnt_s;
  logic            rsp_s;
  logic            keep_s;
  logic [SW-1:0]   credit_s;
  logic [XLEN-1:0] resp_pc_s;

  assign if_valid  = (occ_q != {CW{1'b0}});
  assign if_instr  = instr_q[rd_ptr_q];
  assign if_pc     = ipc_q[rd_ptr_q];
  assign imem_addr = pc_q;

  assign pop_s    = if_valid && if_ready;
  assign credit_s = SW'(inflight_q) + SW'(occ_q) - SW'(pop_s);
  assign imem_req = !areset && (credit_s < SW'(DEPTH)) && !jump;
  assign gnt_s    = imem_req && imem_gnt;
  // A response with nothing outstanding (e.g. left over from before reset) is ignored.
  assign rsp_s    = imem_rvalid && (inflight_q != {CW{1'b0}});
  assign keep_s   = rsp_s && (drop_q == {CW{1'b0}}) && !jump;
  // Once drops are drained, every outstanding request is contiguous below pc_q.
  assign resp_pc_s = pc_q - (XLEN'(inflight_q) << 2);

  // Next-state for PC, counters, FIFO pointers and storage.
  always_comb begin
    pc_d       = pc_q;
    inflight_d = inflight_q + CW'(gnt_s) - CW'(rsp_s);
    occ_d      = occ_q + CW'(keep_s) - CW'(pop_s);
    drop_d     = drop_q;
    rd_ptr_d   = rd_ptr_q + AW'(pop_s);
    wr_ptr_d   = wr_ptr_q + AW'(keep_s);
    instr_d    = instr_q;
    ipc_d      = ipc_q;
    if (keep_s) begin
      instr_d[wr_ptr_q] = imem_rdata;
      ipc_d[wr_ptr_q]   = resp_pc_s;
    end else begin
      instr_d = instr_q;
    end
    if (jump) begin
      pc_d     = jump_target & ~{{(XLEN-2){1'b0}}, 2'b11};
      occ_d    = {CW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      wr_ptr_d = {AW{1'b0}};
      drop_d   = inflight_q - CW'(rsp_s);
    end else begin
      pc_d = gnt_s ? (pc_q + {{(XLEN-3){1'b0}}, 3'd4}) : pc_q;
      if (rsp_s && (drop_q != {CW{1'b0}})) begin
        drop_d = drop_q - {{(CW-1){1'b0}}, 1'b1};
      end else begin
        drop_d = drop_q;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      pc_q       <= RESET_PC;
      inflight_q <= {CW{1'b0}};
      occ_q      <= {CW{1'b0}};
      drop_q     <= {CW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      wr_ptr_q   <= {AW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= {XLEN{1'b0}};
        ipc_q[i]   <= {XLEN{1'b0}};
      end
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      drop_q     <= drop_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      instr_q    <= instr_d;
      ipc_q      <= ipc_d;
    end
  end

  rv32i_fetch_chk #(.CW(CW), .DEPTH(DEPTH)) u_chk (
    .clk      (clk),
    .areset   (areset),
    .push     (keep_s),
    .pop      (pop_s),
    .occ      (occ_q),
    .inflight (inflight_q)
  );

endmodule

// Simulation-only invariants of the fetch buffer and request credit.
module rv32i_fetch_chk #(
  parameter int CW    = 2,
  parameter int DEPTH = 2
) (
  input logic          clk,
  input logic          areset,
  input logic          push,
  input logic          pop,
  input logic [CW-1:0] occ,
  input logic [CW-1:0] inflight
);

  a_no_overflow: assert property (@(posedge clk) disable iff (areset)
    !(push && !pop && (occ == CW'(DEPTH))))
    else $error("fetch buffer push while full");

  a_inflight_bound: assert property (@(posedge clk) disable iff (areset)
    inflight <= CW'(DEPTH))
    else $error("fetch inflight above DEPTH");

endmodule

// File: tb/tb_rv32i_fetch.sv
// Scoreboard bench for rv32i_fetch: in-order memory model with programmable latency,
// expected PC stream predicted from the fetch rules, monitor compares every transfer.
module tb_rv32i_fetch;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;
  localparam logic [31:0] KEY   = 32'hA5A5_0000;

  logic        clk;
  logic        areset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        jump;
  logic [31:0] jump_target;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  int errors = 0;
  int checks = 0;
  int deliveries = 0;
  int cyc = 0;
  int lat_min = 1;
  int lat_max = 1;

  logic [31:0] mem_addr_q[$];
  int          mem_due_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] gen_pc = RPC;
  logic        hold_r = 1'b0;
  logic [31:0] hold_pc;
  logic [31:0] hold_instr;

  rv32i_fetch #(.XLEN(32), .RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .areset      (areset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .jump        (jump),
    .jump_target (jump_target),
    .if_valid    (if_valid),
    .if_ready    (if_ready),
    .if_instr    (if_instr),
    .if_pc       (if_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: memory bookkeeping, scoreboard compare and hold-stability checks.
  always @(negedge clk) begin
    logic [31:0] e;
    if (areset) begin
      mem_addr_q.delete();
      mem_due_q.delete();
      exp_q.delete();
      gen_pc = RPC;
      hold_r = 1'b0;
    end else begin
      if (hold_r) begin
        chk("hold_valid", {31'b0, if_valid}, 32'd1);
        chk("hold_pc", if_pc, hold_pc);
        chk("hold_instr", if_instr, hold_instr);
      end
      if (imem_rvalid && mem_addr_q.size() > 0) begin
        void'(mem_addr_q.pop_front());
        void'(mem_due_q.pop_front());
      end
      if (imem_req && imem_gnt) begin
        chk("addr_align", {30'b0, imem_addr[1:0]}, 32'd0);
        mem_addr_q.push_back(imem_addr);
        mem_due_q.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
        chk("outstanding_le_depth", {31'b0, mem_addr_q.size() <= DEPTH}, 32'd1);
      end
      if (jump) chk("no_req_in_jump", {31'b0, imem_req}, 32'd0);
      if (if_valid && if_ready) begin
        while (exp_q.size() < 4) begin
          exp_q.push_back(gen_pc);
          gen_pc = gen_pc + 32'd4;
        end
        e = exp_q.pop_front();
        chk("sb_pc", if_pc, e);
        chk("sb_instr", if_instr, e ^ KEY);
        deliveries++;
      end
      if (jump) begin
        exp_q.delete();
        gen_pc = jump_target & ~32'h3;
      end
      hold_r     = if_valid && !if_ready && !jump;
      hold_pc    = if_pc;
      hold_instr = if_instr;
    end
  end

  task automatic drive(input logic rdy, input logic gnt, input logic jmp, input logic [31:0] tgt);
    if_ready    = rdy;
    imem_gnt    = gnt;
    jump        = jmp;
    jump_target = tgt;
    if (mem_addr_q.size() > 0 && mem_due_q[0] <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_addr_q[0] ^ KEY;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
  endtask

  task automatic step(input logic rdy, input logic gnt, input logic jmp, input logic [31:0] tgt);
    @(posedge clk);
    #1;
    drive(rdy, gnt, jmp, tgt);
    @(negedge clk);
  endtask

  task automatic check_reset_vals();
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, RPC);
    chk("rst_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_instr", if_instr, 32'd0);
    chk("rst_pc", if_pc, 32'd0);
  endtask

  // Release reset with a stray response in the first cycle; checks 2-cycle latency.
  task automatic release_reset();
    lat_min = 1;
    lat_max = 1;
    @(posedge clk);
    #1;
    areset = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("first_req", {31'b0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, RPC);
    step(1'b1, 1'b1, 1'b0, 32'd0);
    chk("lat_n1_valid", {31'b0, if_valid}, 32'd0);
    step(1'b1, 1'b1, 1'b0, 32'd0);
    chk("lat_n2_valid", {31'b0, if_valid}, 32'd1);
    chk("lat_n2_pc", if_pc, RPC);
  endtask

  initial begin
    int gaps;
    logic found;
    areset      = 1'b1;
    if_ready    = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'd0;
    jump        = 1'b0;
    jump_target = 32'd0;
    repeat (3) @(negedge clk);
    check_reset_vals();
    release_reset();

    gaps = 0;
    repeat (16) begin
      step(1'b1, 1'b1, 1'b0, 32'd0);
      if (!if_valid) gaps++;
    end
    chk("no_gaps", gaps, 32'd0);

    // Jump overlapping a pop and an arriving response, zero-wait memory.
    step(1'b1, 1'b1, 1'b1, 32'h0000_0103);
    chk("jump_pop", {31'b0, if_valid && if_ready}, 32'd1);
    chk("jump_rvalid", {31'b0, imem_rvalid}, 32'd1);
    step(1'b1, 1'b1, 1'b0, 32'd0);
    chk("j1_req", {31'b0, imem_req}, 32'd1);
    chk("j1_addr", imem_addr, 32'h0000_0100);
    chk("j1_valid", {31'b0, if_valid}, 32'd0);
    step(1'b1, 1'b1, 1'b0, 32'd0);
    chk("j2_valid", {31'b0, if_valid}, 32'd0);
    step(1'b1, 1'b1, 1'b0, 32'd0);
    chk("j3_valid", {31'b0, if_valid}, 32'd1);
    chk("j3_pc", if_pc, 32'h0000_0100);

    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b0, 32'd0);
      if (i >= 1) chk("stall_req", {31'b0, imem_req}, 32'd0);
    end
    repeat (8) step(1'b1, 1'b1, 1'b0, 32'd0);

    // Jump with two responses pending on slow memory.
    lat_min = 4;
    lat_max = 4;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      @(posedge clk);
      #1;
      drive(1'b1, 1'b1, 1'b0, 32'd0);
      if (!imem_rvalid && mem_addr_q.size() == 2) begin
        jump        = 1'b1;
        jump_target = 32'h0000_0103;
        found       = 1'b1;
      end
      @(negedge clk);
    end
    chk("two_pending_jump", {31'b0, found}, 32'd1);
    lat_min = 1;
    lat_max = 2;
    repeat (15) step(1'b1, 1'b1, 1'b0, 32'd0);

    lat_min = 3;
    lat_max = 3;
    for (int i = 0; i < 60; i++) step($urandom_range(99) < 80, i[0], 1'b0, 32'd0);

    lat_min = 1;
    lat_max = 3;
    for (int i = 0; i < 600; i++)
      step($urandom_range(99) < 70, $urandom_range(99) < 60, $urandom_range(99) < 4, $urandom);

    // Address wrap at the top of the address space.
    lat_min = 1;
    lat_max = 1;
    repeat (6) step(1'b1, 1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
    step(1'b1, 1'b1, 1'b0, 32'd0);
    chk("wrap_a0", imem_addr, 32'hFFFF_FFF8);
    step(1'b1, 1'b1, 1'b0, 32'd0);
    chk("wrap_a1", imem_addr, 32'hFFFF_FFFC);
    step(1'b1, 1'b1, 1'b0, 32'd0);
    chk("wrap_a2", imem_addr, 32'h0000_0000);
    chk("wrap_req", {31'b0, imem_req}, 32'd1);
    repeat (6) step(1'b1, 1'b1, 1'b0, 32'd0);

    // Asynchronous reset in the middle of a stream.
    @(posedge clk);
    #3;
    areset = 1'b1;
    #1;
    check_reset_vals();
    repeat (2) @(negedge clk);
    release_reset();
    repeat (10) step(1'b1, 1'b1, 1'b0, 32'd0);

    chk("deliveries_min", {31'b0, deliveries > 200}, 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
